noc_local_injector: RTL

Credit-based flit transmitter driving a router input port (rx/data_in/credit_o) from the local processing element side. It accepts a packet descriptor (target address, payload size) plus a payload flit stream, and emits header flit, size flit, then payload flits on tx/data_out, obeying credit_i. It is the sending end of the router's local-port protocol and instantiates once per tile between the PE and router port LOCAL.

---
 rtl/noc_local_injector.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/noc_local_injector.sv
// Credit-based flit transmitter feeding a router local input port.
// Sends header (target), size, then payload flits; a flit moves when tx && credit_i.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no packet in flight, descriptor may be accepted
// HEADER  | header flit (target) on data_out, waiting for credit
// SIZE    | size flit on data_out, first payload fetched on its accept
// PAYLOAD | streaming payload flits, remaining > 0 still to be loaded
// DRAIN   | last payload flit on data_out, waiting for its accept
module noc_local_injector #(
    parameter int FLIT_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [FLIT_WIDTH-1:0] pkt_target,
    input  logic [FLIT_WIDTH-1:0] pkt_size,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic [FLIT_WIDTH-1:0] pl_data,
    output logic                  clock_tx,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_out,
    input  logic                  credit_i,
    output logic                  busy,
    output logic                  pkt_done,
    output logic [CNT_WIDTH-1:0]  flits_sent
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        SIZE    = 3'd2,
        PAYLOAD = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  tx_d;
    logic [FLIT_WIDTH-1:0] data_d;
    logic                  done_d;
    logic [FLIT_WIDTH-1:0] size_q, size_d;
    logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;

    logic accept;
    logic slot_free;
    logic size_zero;

    assign clock_tx  = clock;
    assign accept    = tx && credit_i;
    assign slot_free = !tx || credit_i;
    assign size_zero = (size_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            tx          <= 1'b0;
            data_out    <= '0;
            pkt_done    <= 1'b0;
            size_q      <= '0;
            remaining_q <= '0;
            flits_sent  <= '0;
        end else begin
            state_q     <= state_d;
            tx          <= tx_d;
            data_out    <= data_d;
            pkt_done    <= done_d;
            size_q      <= size_d;
            remaining_q <= remaining_d;
            if (accept) begin
                flits_sent <= flits_sent + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx;
        data_d      = data_out;
        done_d      = 1'b0;
        size_d      = size_q;
        remaining_d = remaining_q;
        // Holding pkt_ready low during the pkt_done cycle gives the fixed
        // one-cycle gap the router side expects between packets.
        pkt_ready   = (state_q == IDLE) && !pkt_done;
        pl_ready    = 1'b0;
        busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (pkt_valid && pkt_ready) begin
                    size_d  = pkt_size;
                    data_d  = pkt_target;
                    tx_d    = 1'b1;
                    state_d = HEADER;
                end
            end

            HEADER: begin
                if (accept) begin
                    data_d  = size_q;
                    tx_d    = 1'b1;
                    state_d = SIZE;
                end
            end

            SIZE: begin
                pl_ready = !size_zero && credit_i;
                if (accept) begin
                    if (size_zero) begin
                        tx_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (pl_valid) begin
                        data_d      = pl_data;
                        tx_d        = 1'b1;
                        remaining_d = size_q - FLIT_WIDTH'(1);
                        state_d     = (size_q == FLIT_WIDTH'(1)) ? DRAIN : PAYLOAD;
                    end else begin
                        tx_d        = 1'b0;
                        remaining_d = size_q;
                        state_d     = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                pl_ready = slot_free;
                if (slot_free) begin
                    if (pl_valid) begin
                        data_d      = pl_data;
                        tx_d        = 1'b1;
                        remaining_d = remaining_q - FLIT_WIDTH'(1);
                        if (remaining_q == FLIT_WIDTH'(1)) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        tx_d = 1'b0;
                    end
                end
            end

            DRAIN: begin
                if (accept) begin
                    tx_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                tx_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
